// File: rtl/sar_ctrl.sv
// Successive-approximation controller: samples, then walks the DAC code MSB-first
// using qualified comparator decisions, with a per-compare timeout fallback.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start; last result held
// S_SAMPLE  | track/hold switch closed for SAMPLE_CYCLES
// S_SETTLE  | DAC settling for SETTLE_CYCLES, comparator disabled
// S_COMPARE | comparator enabled, waiting for valid or timeout
// S_DONE    | one-cycle done pulse, result visible
module sar_ctrl #(
  parameter int N_BITS         = 8,
  parameter int SAMPLE_CYCLES  = 4,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              comp,
  input  logic              valid,
  output logic              sample,
  output logic              cmp_en,
  output logic [N_BITS-1:0] dac_code,
  output logic              busy,
  output logic [N_BITS-1:0] result,
  output logic              done,
  output logic              timeout_err
);

  localparam int MAX_A = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int MAXP  = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W = $clog2(MAXP + 1);
  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [CNT_W-1:0] SAMPLE_TC  = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_TC  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [N_BITS-1:0]  dac_n, result_n;
  logic               terr_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= IDX_MSB;
      dac_code    <= '0;
      result      <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      dac_code    <= dac_n;
      result      <= result_n;
      timeout_err <= terr_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    dac_n    = dac_code;
    result_n = result;
    terr_n   = timeout_err;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SAMPLE;
          cnt_n   = '0;
          dac_n   = '0;
          terr_n  = 1'b0;
        end
      end
      S_SAMPLE: begin
        if (cnt == SAMPLE_TC) begin
          state_n           = S_SETTLE;
          cnt_n             = '0;
          dac_n             = '0;
          dac_n[N_BITS-1]   = 1'b1;
          idx_n             = IDX_MSB;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_TC) begin
          state_n = S_COMPARE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_COMPARE: begin
        // A timeout keeps the trial bit, as if comp=1; valid on the same cycle wins.
        if (valid || (cnt == TIMEOUT_TC)) begin
          cnt_n = '0;
          if (valid && !comp) dac_n[idx] = 1'b0;
          if (!valid) terr_n = 1'b1;
          if (idx != '0) begin
            dac_n[idx - 1'b1] = 1'b1;
            idx_n             = idx - 1'b1;
            state_n           = S_SETTLE;
          end else begin
            result_n = dac_n;
            state_n  = S_DONE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Result is loaded on DONE entry so it is already valid while done is high.
  assign sample = (state == S_SAMPLE);
  assign cmp_en = (state == S_COMPARE);
  assign busy   = (state != S_IDLE);
  assign done   = (state == S_DONE);

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl: a comparator plant (comp = vin >= dac_code) answers
// each compare after a programmable delay; vectors hold hand-computed results/latencies.
module tb_sar_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, comp, valid;
  logic       sample, cmp_en, busy, done, timeout_err;
  logic [7:0] dac_code, result;

  int checks   = 0;
  int failures = 0;

  sar_ctrl #(
    .N_BITS(8), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .comp(comp), .valid(valid),
    .sample(sample), .cmp_en(cmp_en), .dac_code(dac_code), .busy(busy),
    .result(result), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vin;
    int         vdelay;   // COMPARE cycles before valid is raised
    bit         to_msb;   // withhold valid for the whole MSB trial
    bit         noise;    // valid=1 with toggling comp outside COMPARE
    bit         poke;     // pulse start while busy and in DONE
    logic [7:0] exp_res;
    bit         exp_terr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit in_settle();
    return busy && !sample && !cmp_en && !done;
  endfunction

  task automatic run_conv(input vec_t v);
    int lat = -1, dcnt = 0, busy_after = 0, cmp_cnt = 0, trial = 0;
    int c1 = -1, tfirst = -1, stable_err = 0;
    logic [7:0] prev_dac = '0, res_at_done = '0;
    logic terr_start = 1'b1;
    bit prev_settle = 0, settle;
    @(negedge clk);
    start = 1'b1; valid = 1'b0; comp = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      start = (v.poke && (cyc == 10 || done)) ? 1'b1 : 1'b0;
      if (cyc == 1) terr_start = timeout_err;
      settle = in_settle();
      if (prev_settle && (settle || cmp_en) && dac_code !== prev_dac) stable_err++;
      prev_settle = settle;
      prev_dac    = dac_code;
      if (done) begin
        dcnt++;
        if (lat < 0) begin lat = cyc; res_at_done = result; end
      end
      if (lat >= 0 && cyc > lat && busy) busy_after++;
      if (timeout_err && tfirst < 0) tfirst = cyc;
      if (cmp_en) begin
        cmp_cnt++;
        if (cmp_cnt == 1) begin
          trial++;
          if (c1 < 0) c1 = cyc;
        end
        valid = (cmp_cnt > v.vdelay) && !(v.to_msb && trial == 1);
        comp  = (v.vin >= dac_code);
      end else begin
        cmp_cnt = 0;
        valid   = v.noise;
        comp    = v.noise ? ~comp : 1'b0;
      end
      if (lat >= 0 && cyc >= lat + 4) break;
    end
    start = 1'b0; valid = 1'b0; comp = 1'b0;
    check("result_at_done", 32'(res_at_done), 32'(v.exp_res));
    check("result_held", 32'(result), 32'(v.exp_res));
    check("latency", lat, v.exp_lat);
    check("done_pulses", dcnt, 1);
    check("busy_after_done", busy_after, 0);
    check("dac_stable_settle", stable_err, 0);
    check("terr_cleared_on_start", 32'(terr_start), 0);
    check("timeout_err", 32'(timeout_err), 32'(v.exp_terr));
    if (v.to_msb) check("timeout_delay", tfirst - c1, 16);
  endtask

  initial begin
    //          vin    dly msb noi pok  exp    terr lat
    vecs[0] = '{8'hA5, 0, 0, 0, 0, 8'hA5, 0, 29};
    vecs[1] = '{8'hA5, 1, 0, 0, 0, 8'hA5, 0, 37};
    vecs[2] = '{8'hFF, 0, 0, 0, 0, 8'hFF, 0, 29};
    vecs[3] = '{8'h00, 2, 0, 0, 0, 8'h00, 0, 45};
    vecs[4] = '{8'h25, 0, 1, 0, 0, 8'h80, 1, 44};
    vecs[5] = '{8'hA5, 1, 0, 1, 0, 8'hA5, 0, 37};
    vecs[6] = '{8'h5A, 0, 0, 0, 1, 8'h5A, 0, 29};

    rst = 1'b1; start = 1'b1; comp = 1'b1; valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs",
            32'({sample, cmp_en, busy, done, timeout_err, dac_code, result}), 0);
    end
    rst = 1'b0; start = 1'b0; comp = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'(busy), 0);

    for (int i = 0; i < 7; i++) run_conv(vecs[i]);

    // Reset during the second SETTLE phase of a fresh conversion.
    begin
      int  n_settle = 0;
      bit  found    = 0;
      bit  prev     = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200; i++) begin
        if (cmp_en) valid = 1'b1;
        else valid = 1'b0;
        comp = 1'b1;
        if (in_settle() && !prev) n_settle++;
        prev = in_settle();
        if (n_settle == 2) begin found = 1; break; end
        @(negedge clk);
      end
      check("settle_reached", 32'(found), 1);
      valid = 1'b0;
      rst   = 1'b1;
      @(negedge clk);
      check("rst_mid_settle_busy", 32'(busy), 0);
      check("rst_mid_settle_result", 32'(result), 0);
      check("rst_mid_settle_dac", 32'(dac_code), 0);
      rst = 1'b0;
    end

    run_conv(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
